// File: rtl/timer_reg_if.sv
// timer_reg_if: strobe/bus signals between the APB slave FSM and the timer register core
interface timer_reg_if #(
  parameter int ADDR_W = 12
) ();
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] tim_paddr;
  logic [31:0]       tim_pwdata;
  logic [3:0]        tim_pstrb;
  logic [31:0]       tim_prdata;
  logic              reg_error_flag;
  modport master (
    output wr_en, rd_en, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_prdata, reg_error_flag
  );
  modport slave (
    input  wr_en, rd_en, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_prdata, reg_error_flag
  );
endinterface

// File: rtl/timer_reg_core.sv
// timer_reg_core: APB timer register bank, prescaled 64-bit counter and compare interrupt (byte strobes enabled by TIMER_BYTE_STROBE_EN)
module timer_reg_core #(
  parameter int          ADDR_W  = 12,
  parameter logic [63:0] CNT_RST = 64'h0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  timer_reg_if.slave bus,
  input  logic       dbg_mode,
  output logic       tim_int
);
  logic              timer_en_q, timer_en_d;
  logic              div_en_q, div_en_d;
  logic [3:0]        div_val_q, div_val_d;
  logic [63:0]       cnt_q, cnt_d;
  logic [63:0]       cmp_q, cmp_d;
  logic              int_en_q, int_en_d;
  logic              int_st_q, int_st_d;
  logic              halt_req_q, halt_req_d;
  logic              halt_ack_q, halt_ack_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [ADDR_W-3:0] idx;
  logic              mapped;
  logic [7:0]        sel, wr;
  logic [31:0]       wmask, rd_val, merged;
  logic              err, tcr_ok, tcr_dis, cnt_en, tick, w1c;
  logic [8:0]        lim;
  logic [63:0]       cnt_inc;
  logic              unused_bits;
  assign idx    = bus.tim_paddr[ADDR_W-1:2];
  assign mapped = (idx >> 3) == '0;
  assign sel    = mapped ? 8'd1 << idx[2:0] : 8'd0;
  assign wr     = bus.wr_en ? sel : 8'd0;
`ifdef TIMER_BYTE_STROBE_EN
  assign wmask       = {{8{bus.tim_pstrb[3]}}, {8{bus.tim_pstrb[2]}}, {8{bus.tim_pstrb[1]}}, {8{bus.tim_pstrb[0]}}};
  assign unused_bits = ^bus.tim_paddr[1:0];
`else
  assign wmask       = 32'hFFFF_FFFF;
  assign unused_bits = ^{bus.tim_paddr[1:0], bus.tim_pstrb};
`endif
  // current contents of the addressed register; also the base for strobe merging
  always_comb begin
    rd_val = 32'h0;
    if (mapped)
      case (idx[2:0])
        3'd0: rd_val = {20'h0, div_val_q, 6'h0, div_en_q, timer_en_q};
        3'd1: rd_val = cnt_q[31:0];
        3'd2: rd_val = cnt_q[63:32];
        3'd3: rd_val = cmp_q[31:0];
        3'd4: rd_val = cmp_q[63:32];
        3'd5: rd_val = {31'h0, int_en_q};
        3'd6: rd_val = {31'h0, int_st_q};
        default: rd_val = {30'h0, halt_ack_q, halt_req_q};
      endcase
  end
  assign merged  = (rd_val & ~wmask) | (bus.tim_pwdata & wmask);
  assign err     = sys_rst_n & wr[0] & ((merged[11:8] > 4'd8) |
                   (timer_en_q & ((merged[11:8] != div_val_q) | (merged[1] != div_en_q))));
  assign tcr_ok  = wr[0] & ~err;
  assign tcr_dis = tcr_ok & timer_en_q & ~merged[0];
  assign cnt_en  = timer_en_q & ~halt_ack_q;
  assign lim     = (9'd1 << div_val_q) - 9'd1;
  assign tick    = cnt_en & (div_en_q ? ({1'b0, div_cnt_q} == lim) : 1'b1);
  assign cnt_inc = cnt_q + {63'h0, tick};
  assign w1c     = wr[6] & bus.tim_pwdata[0] & wmask[0];
  assign bus.tim_prdata     = (bus.rd_en & sys_rst_n) ? rd_val : 32'h0;
  assign bus.reg_error_flag = err;
  assign tim_int            = int_en_q & int_st_q;
  // next-state for every register; a TDR write replaces only its own word of the incremented count
  always_comb begin
    timer_en_d = tcr_ok ? merged[0] : timer_en_q;
    div_en_d   = tcr_ok ? merged[1] : div_en_q;
    div_val_d  = tcr_ok ? merged[11:8] : div_val_q;
    div_cnt_d  = (!cnt_en || tcr_dis || !div_en_q || tick) ? 8'd0 : div_cnt_q + 8'd1;
    cnt_d      = tcr_dis ? CNT_RST : {wr[2] ? merged : cnt_inc[63:32], wr[1] ? merged : cnt_inc[31:0]};
    cmp_d      = {wr[4] ? merged : cmp_q[63:32], wr[3] ? merged : cmp_q[31:0]};
    int_en_d   = wr[5] ? merged[0] : int_en_q;
    int_st_d   = (cnt_q == cmp_q) | (int_st_q & ~w1c);
    halt_req_d = wr[7] ? merged[0] : halt_req_q;
    halt_ack_d = halt_req_q & dbg_mode;
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      timer_en_q <= 1'b0;
      div_en_q   <= 1'b0;
      div_val_q  <= 4'd1;
      div_cnt_q  <= 8'd0;
      cnt_q      <= CNT_RST;
      cmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
      int_en_q   <= 1'b0;
      int_st_q   <= 1'b0;
      halt_req_q <= 1'b0;
      halt_ack_q <= 1'b0;
    end else begin
      timer_en_q <= timer_en_d;
      div_en_q   <= div_en_d;
      div_val_q  <= div_val_d;
      div_cnt_q  <= div_cnt_d;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      int_en_q   <= int_en_d;
      int_st_q   <= int_st_d;
      halt_req_q <= halt_req_d;
      halt_ack_q <= halt_ack_d;
    end
endmodule

// File: tb/tb_timer_reg_core.sv
// tb_timer_reg_core: directed vectors for timer_reg_core checked through an expected-response queue
module tb_timer_reg_core;
  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] addr;
    logic [31:0] exp;
  } sb_t;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic dbg_mode = 1'b0;
  logic tim_int;
  logic probe = 1'b0;
  logic [3:0] strb = 4'hF;
  sb_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  timer_reg_if #(.ADDR_W(12)) bus ();
  timer_reg_core #(.ADDR_W(12), .CNT_RST(64'h0)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave),
    .dbg_mode (dbg_mode),
    .tim_int  (tim_int)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic push(input logic [1:0] k, input logic [11:0] a, input logic [31:0] e);
    sb_t t;
    t.kind = k;
    t.addr = a;
    t.exp  = e;
    sb.push_back(t);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic e);
    push(2'd1, a, {31'h0, e});
    bus.wr_en = 1'b1;
    bus.tim_paddr = a;
    bus.tim_pwdata = d;
    bus.tim_pstrb = strb;
    @(posedge sys_clk);
    #1;
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    push(2'd0, a, e);
    bus.rd_en = 1'b1;
    bus.tim_paddr = a;
    @(posedge sys_clk);
    #1;
    bus.rd_en = 1'b0;
  endtask
  task automatic chk_int(input logic e);
    push(2'd2, 12'h0, {31'h0, e});
    probe = 1'b1;
    @(posedge sys_clk);
    #1;
    probe = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  // monitor: pops one expectation per presented access/probe
  always @(negedge sys_clk)
    if (sys_rst_n && (bus.wr_en || bus.rd_en || probe)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: access with no expected entry");
      end else begin
        sb_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = (e.kind == 2'd0) ? bus.tim_prdata : (e.kind == 2'd1) ? {31'h0, bus.reg_error_flag} : {31'h0, tim_int};
        n_vec++;
        if (got !== e.exp) begin
          n_err++;
          $display("FAIL %s @%h: got %h expected %h",
                   (e.kind == 2'd0) ? "read" : (e.kind == 2'd1) ? "wr_err" : "tim_int", e.addr, got, e.exp);
        end
      end
    end
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.tim_paddr = '0;
    bus.tim_pwdata = '0;
    bus.tim_pstrb = 4'hF;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    rd(12'h000, 32'h0000_0100);
    rd(12'h004, 32'h0);
    rd(12'h008, 32'h0);
    rd(12'h00C, 32'hFFFF_FFFF);
    rd(12'h010, 32'hFFFF_FFFF);
    rd(12'h014, 32'h0);
    rd(12'h018, 32'h0);
    rd(12'h01C, 32'h0);
    chk_int(1'b0);
    wr(12'h000, 32'h1, 1'b0);
    idle(10);
    rd(12'h004, 32'd10);
    wr(12'h000, 32'h0, 1'b0);
    rd(12'h004, 32'h0);
    rd(12'h008, 32'h0);
    wr(12'h000, 32'h203, 1'b0);
    idle(7);
    rd(12'h004, 32'd1);
    idle(3);
    rd(12'h004, 32'd2);
    wr(12'h000, 32'h303, 1'b1);
    rd(12'h000, 32'h203);
    wr(12'h000, 32'h202, 1'b0);
    wr(12'h000, 32'h900, 1'b1);
    rd(12'h000, 32'h202);
    wr(12'h000, 32'h100, 1'b0);
    rd(12'h004, 32'h0);
    wr(12'h008, 32'h0, 1'b0);
    wr(12'h004, 32'hFFFF_FFFE, 1'b0);
    wr(12'h000, 32'h1, 1'b0);
    idle(2);
    rd(12'h004, 32'h0);
    rd(12'h008, 32'h1);
    wr(12'h000, 32'h0, 1'b0);
    wr(12'h004, 32'hFFFF_FFFF, 1'b0);
    wr(12'h008, 32'hFFFF_FFFF, 1'b0);
    wr(12'h000, 32'h1, 1'b0);
    idle(1);
    rd(12'h004, 32'h0);
    rd(12'h008, 32'h0);
    wr(12'h000, 32'h0, 1'b0);
    rd(12'h018, 32'h1);
    wr(12'h018, 32'h1, 1'b0);
    rd(12'h018, 32'h0);
    wr(12'h00C, 32'h10, 1'b0);
    wr(12'h010, 32'h0, 1'b0);
    wr(12'h014, 32'h1, 1'b0);
    wr(12'h000, 32'h1, 1'b0);
    idle(15);
    chk_int(1'b0);
    chk_int(1'b0);
    chk_int(1'b1);
    wr(12'h018, 32'h1, 1'b0);
    chk_int(1'b0);
    wr(12'h000, 32'h0, 1'b0);
    wr(12'h004, 32'h10, 1'b0);
    wr(12'h018, 32'h1, 1'b0);
    chk_int(1'b1);
    rd(12'h018, 32'h1);
    wr(12'h004, 32'h0, 1'b0);
    wr(12'h018, 32'h1, 1'b0);
    rd(12'h018, 32'h0);
    chk_int(1'b0);
    wr(12'h014, 32'h0, 1'b0);
    dbg_mode = 1'b1;
    wr(12'h000, 32'h1, 1'b0);
    wr(12'h01C, 32'h1, 1'b0);
    idle(3);
    rd(12'h01C, 32'h3);
    rd(12'h004, 32'd2);
    idle(3);
    rd(12'h004, 32'd2);
    dbg_mode = 1'b0;
    idle(1);
    rd(12'h004, 32'd2);
    rd(12'h004, 32'd3);
    rd(12'h01C, 32'h1);
    wr(12'h01C, 32'h0, 1'b0);
    wr(12'h000, 32'h0, 1'b0);
    wr(12'h00C, 32'hFFFF_FFFF, 1'b0);
    strb = 4'b0001;
    wr(12'h00C, 32'hAABB_CCDD, 1'b0);
    strb = 4'hF;
`ifdef TIMER_BYTE_STROBE_EN
    rd(12'h00C, 32'hFFFF_FFDD);
    strb = 4'h0;
    wr(12'h000, 32'hFFF, 1'b0);
    strb = 4'hF;
    rd(12'h000, 32'h0);
`else
    rd(12'h00C, 32'hAABB_CCDD);
`endif
    wr(12'h040, 32'h1, 1'b0);
    rd(12'h040, 32'h0);
    rd(12'h020, 32'h0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge sys_clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/timer_reg_core.md
Name: timer_reg_core

Overview:
Register bank and 64-bit counter engine for the APB timer. It sits directly downstream of the APB slave FSM and consumes its single-cycle wr_en/rd_en strobes. It decodes the APB address, performs register reads and writes, runs the prescaled counter and compare interrupt, and returns reg_error_flag combinationally in the same cycle so the FSM can form tim_pslverr.

Parameters:
ADDR_W, 12, width of tim_paddr; only bits [ADDR_W-1:2] are decoded, word aligned
CNT_RST, 64'h0, reset and clear value of the counter

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
wr_en  in  1  one-cycle write strobe (ACCESS && pwrite)
rd_en  in  1  one-cycle read strobe (ACCESS && !pwrite)
tim_paddr  in  ADDR_W  APB address
tim_pwdata  in  32  APB write data
tim_pstrb  in  4  APB byte strobes
dbg_mode  in  1  debug-mode request from the CPU
tim_prdata  out  32  read data, valid while rd_en is high
reg_error_flag  out  1  combinational error for the current access
tim_int  out  1  level interrupt

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; clock is sys_clk. All outputs are 0 during reset. Register reset values are listed with the map.
- Register map (offset: fields):
  - 0x00 TCR: [0] timer_en (rst 0); [1] div_en (rst 0); [11:8] div_val (rst 1).
  - 0x04 TDR0: counter[31:0].
  - 0x08 TDR1: counter[63:32].
  - 0x0C TCMP0: cmp[31:0] (rst FFFF_FFFF).
  - 0x10 TCMP1: cmp[63:32] (rst FFFF_FFFF).
  - 0x14 TIER: [0] int_en (rst 0).
  - 0x18 TISR: [0] int_st, write-1-to-clear.
  - 0x1C THCSR: [0] halt_req (RW, rst 0); [1] halt_ack (RO).
  - All other bits read 0; writes to them are ignored.
- Writes take effect at the sys_clk edge where wr_en=1.
- Reads: tim_prdata = decoded register when rd_en=1, else 32'h0 (combinational, no latency).
- Unmapped offsets: read 0, writes ignored, no error.
- reg_error_flag is combinational and asserts only when wr_en=1 to TCR and either condition holds:
  - the written div_val > 8;
  - timer_en=1 and the write changes div_val or div_en.
  - On error the whole TCR write is dropped (no fields update).
- halt_ack = halt_req & dbg_mode (registered, 1-cycle latency).
- cnt_en = timer_en & !halt_ack.
- Prescaler: 8-bit internal div_cnt.
  - div_en=0: counter increments every cnt_en cycle.
  - div_en=1: div_cnt increments each cnt_en cycle; when div_cnt == (1<<div_val)-1, counter increments and div_cnt returns to 0.
  - div_val=0 with div_en=1 counts every cycle.
  - div_cnt clears whenever cnt_en=0 or timer_en is written 1->0.
- Counter: 64-bit, wraps FFFF_FFFF_FFFF_FFFF -> 0; the carry from low to high word occurs in the same cycle.
  - timer_en 1->0 clears the counter to CNT_RST.
  - A write to TDR0/TDR1 overrides an increment in the same cycle; the other word keeps its value plus any carry from that cycle.
- Interrupt:
  - int_st sets in any cycle where counter == cmp (full 64 bits), regardless of timer_en.
  - A W1C write clears int_st, but set wins if both occur in the same cycle.
  - tim_int = int_en & int_st, registered-free (combinational from flops).
- Reset asserted mid-count: everything returns to reset values immediately; no partial write survives.

Optional Feature:
TIMER_BYTE_STROBE_EN
- Defined: tim_pstrb[i] gates writes of byte i on every register. A pstrb=0 write is a no-op (no error). The TCR error check uses the merged value (old bytes + strobed bytes).
- Undefined: tim_pstrb is ignored and all 4 bytes are always written.

Test Plan:
- Reset, then read each 0x00-0x1C: TCR=0x0000_0100, TCMP0/1=FFFF_FFFF, all others 0; reg_error_flag=0.
- Write TCR=0x1, run 10 cycles, write TCR=0x0: TDR0 reads ~10 while running; counter reads 0 after the disable.
- TCR=0x203 (div_en, div_val=2): counter increments once per 4 cycles. A later write of TCR=0x303 while enabled gives reg_error_flag=1 and TCR is unchanged. A write of div_val=9 with timer disabled is rejected the same way.
- TDR1=0, TDR0=FFFF_FFFE, enable: after 2 increments TDR1=1, TDR0=0. Preload FFFF_FFFF_FFFF_FFFF, enable: counter wraps to 0.
- TCMP=0x0000_0000_0000_0010, TIER=1, enable: tim_int rises when counter=0x10. W1C TISR=1 drops tim_int. W1C issued in the equality cycle leaves int_st=1.
- THCSR=1 with dbg_mode=1: halt_ack=1 and the counter freezes. dbg_mode=0 resumes counting.
- With TIMER_BYTE_STROBE_EN defined: pstrb=4'b0001 write of TCMP0=0xAABBCCDD gives TCMP0=FFFF_FFDD.
